aes_round_ctrl: RTL and testbench

- Sequences one AES block through the shared combinational round datapath (sub bytes -> shift rows -> mix columns -> add round key), one round per accepted round key.
- Owns the 128-bit state register, the round counter, the round-key request handshake to the key schedule, and the mix-columns bypass on the final round.
- Sits between the input block FIFO (valid/ready) and the output block sink (valid/ready).

---
 rtl/aes_round_ctrl.sv | 120 ++++++++++++
 tb/tb_aes_round_ctrl.sv | 492 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_ctrl.sv
// AES round sequencer: loads a block, walks it through one round per accepted round key, then presents the ciphertext.
// Latency NUM_ROUNDS+2 cycles from input handshake with keys always valid; stalls on i_key_valid low, holds output until i_ready.
module aes_round_ctrl #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic         clk,
    input  logic         n_rst,
    input  logic         i_clear,
    input  logic         i_valid,
    input  logic [127:0] i_data,
    output logic         o_ready,
    output logic         o_key_req,
    output logic [3:0]   o_key_round,
    input  logic         i_key_valid,
    input  logic [127:0] i_round_key,
    output logic [127:0] o_dp_state,
    output logic         o_dp_last,
    input  logic [127:0] i_dp_result,
    output logic         o_valid,
    output logic [127:0] o_data,
    input  logic         i_ready
);

    localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_KEY,
        S_DONE
    } state_t;

    state_t       r_fsm;
    logic [127:0] r_state;
    logic [3:0]   r_round;
    logic         r_ready;
    logic         r_key_req;
    logic         r_last;
    logic         r_valid;

    logic [3:0]   w_round_nxt;
    logic [127:0] w_key_state;

    assign w_round_nxt = r_round + 4'd1;
    // Round 0 is the bare initial key whitening; the datapath result only applies from round 1 on.
    assign w_key_state = (r_round == 4'd0) ? (r_state ^ i_round_key) : i_dp_result;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_fsm     <= S_IDLE;
            r_state   <= '0;
            r_round   <= '0;
            r_ready   <= 1'b1;
            r_key_req <= 1'b0;
            r_last    <= 1'b0;
            r_valid   <= 1'b0;
        end else if (i_clear) begin
            r_fsm     <= S_IDLE;
            r_state   <= '0;
            r_round   <= '0;
            r_ready   <= 1'b1;
            r_key_req <= 1'b0;
            r_last    <= 1'b0;
            r_valid   <= 1'b0;
        end else begin
            case (r_fsm)
                S_IDLE: begin
                    if (i_valid) begin
                        r_fsm     <= S_KEY;
                        r_state   <= i_data;
                        r_round   <= '0;
                        r_ready   <= 1'b0;
                        r_key_req <= 1'b1;
                        r_last    <= 1'b0;
                    end
                end
                S_KEY: begin
                    if (i_key_valid) begin
                        r_state <= w_key_state;
                        if (r_round == LAST_ROUND) begin
                            r_fsm     <= S_DONE;
                            r_key_req <= 1'b0;
                            r_last    <= 1'b0;
                            r_valid   <= 1'b1;
                        end else begin
                            r_round <= w_round_nxt;
                            r_last  <= (w_round_nxt == LAST_ROUND);
                        end
                    end
                end
                S_DONE: begin
                    // o_ready rises only after the output handshake cycle, so no block is taken in it.
                    if (i_ready) begin
                        r_fsm   <= S_IDLE;
                        r_round <= '0;
                        r_ready <= 1'b1;
                        r_valid <= 1'b0;
                    end
                end
                default: begin
                    r_fsm     <= S_IDLE;
                    r_state   <= '0;
                    r_round   <= '0;
                    r_ready   <= 1'b1;
                    r_key_req <= 1'b0;
                    r_last    <= 1'b0;
                    r_valid   <= 1'b0;
                end
            endcase
        end
    end

    assign o_ready     = r_ready;
    assign o_key_req   = r_key_req;
    assign o_key_round = r_round;
    assign o_dp_state  = r_state;
    assign o_dp_last   = r_last;
    assign o_valid     = r_valid;
    assign o_data      = r_valid ? r_state : '0;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl with a behavioural AES-128 round datapath and key schedule.
module tb_aes_round_ctrl;

    localparam logic [127:0] PT_C1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K_C1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] K_B   = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;

    logic         clk;
    logic         n_rst;
    logic         i_clear;
    logic         i_valid;
    logic [127:0] i_data;
    logic         o_ready;
    logic         o_key_req;
    logic [3:0]   o_key_round;
    logic         i_key_valid;
    logic [127:0] i_round_key;
    logic [127:0] o_dp_state;
    logic         o_dp_last;
    logic [127:0] i_dp_result;
    logic         o_valid;
    logic [127:0] o_data;
    logic         i_ready;

    int errors = 0;
    int checks = 0;

    logic [7:0]   sb [256];
    logic [127:0] rk_a [11];
    logic [127:0] rk_b [11];
    bit           key_sel;

    aes_round_ctrl #(.NUM_ROUNDS(10)) dut (
        .clk(clk), .n_rst(n_rst), .i_clear(i_clear), .i_valid(i_valid), .i_data(i_data),
        .o_ready(o_ready), .o_key_req(o_key_req), .o_key_round(o_key_round),
        .i_key_valid(i_key_valid), .i_round_key(i_round_key), .o_dp_state(o_dp_state),
        .o_dp_last(o_dp_last), .i_dp_result(i_dp_result), .o_valid(o_valid),
        .o_data(o_data), .i_ready(i_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time %0t, required finish", $time);
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xt(aa);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_calc(input logic [7:0] x);
        logic [7:0] inv;
        logic [7:0] t;
        logic [7:0] s;
        inv = 8'h01;
        for (int i = 0; i < 254; i++) inv = gm(inv, x);
        if (x == 8'h00) inv = 8'h00;
        t = inv;
        s = inv;
        for (int i = 0; i < 4; i++) begin
            t = {t[6:0], t[7]};
            s = s ^ t;
        end
        return s ^ 8'h63;
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic last);
        logic [7:0]   b [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) b[i] = sb[s[8*(15-i) +: 8]];
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) t[r + 4*c] = b[r + 4*((c + r) % 4)];
        if (!last) begin
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                t[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                t[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                t[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                t[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
            end
        end
        for (int i = 0; i < 16; i++) o[8*(15-i) +: 8] = t[i];
        return o ^ k;
    endfunction

    task automatic expand(input logic [127:0] key, input bit sel);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[32*(3-i) +: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
                t = t ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) begin
            if (sel) rk_b[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
            else     rk_a[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        end
    endtask

    function automatic logic [127:0] encrypt(input logic [127:0] pt, input bit sel);
        logic [127:0] s;
        s = pt ^ (sel ? rk_b[0] : rk_a[0]);
        for (int r = 1; r <= 10; r++) s = aes_round(s, sel ? rk_b[r] : rk_a[r], r == 10);
        return s;
    endfunction

    always_comb begin
        int idx;
        idx = int'(o_key_round);
        i_round_key = '0;
        if (idx <= 10) i_round_key = key_sel ? rk_b[idx] : rk_a[idx];
    end

    always_comb i_dp_result = aes_round(o_dp_state, i_round_key, o_dp_last);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [127:0] d);
        int n;
        n = 0;
        i_data = d;
        i_valid = 1'b1;
        while (!o_ready && n < 50) begin
            tick();
            n++;
        end
        checks++;
        if (o_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_ready: o_ready=%b after %0d cycles, required 1", o_ready, n);
        end
        tick();
        i_valid = 1'b0;
        i_data = '0;
    endtask

    // Call in the cycle after the input handshake; returns the cycle count at which o_valid appears.
    task automatic run_to_done(output int lat, output int nrounds, output int bad);
        lat = 1;
        nrounds = 0;
        bad = 0;
        i_key_valid = 1'b1;
        while (!o_valid && lat <= 100) begin
            if (o_key_req) begin
                if (o_key_round !== 4'(nrounds)) bad++;
                if (o_dp_last !== (nrounds == 10)) bad++;
                nrounds++;
            end else if (o_dp_last !== 1'b0) begin
                bad++;
            end
            tick();
            lat++;
        end
    endtask

    task automatic drain();
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
    endtask

    task automatic test_reset();
        n_rst = 1'b1;
        #2 n_rst = 1'b0;
        #3;
        checks++;
        if ({o_ready, o_key_req, o_valid, o_dp_last} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_flags: ready/req/valid/last=%b, required 1000",
                     {o_ready, o_key_req, o_valid, o_dp_last});
        end
        checks++;
        if (o_data !== '0 || o_dp_state !== '0 || o_key_round !== 4'd0) begin
            errors++;
            $display("FAIL reset_data: o_data=%h o_dp_state=%h round=%0d, required all zero",
                     o_data, o_dp_state, o_key_round);
        end
        @(negedge clk);
        n_rst = 1'b1;
        tick();
        i_key_valid = 1'b1;
        tick();
        checks++;
        if (o_key_req !== 1'b0 || o_ready !== 1'b1) begin
            errors++;
            $display("FAIL idle_key_ignored: req=%b ready=%b, required 0/1", o_key_req, o_ready);
        end
    endtask

    task automatic test_fips();
        int lat, nr, bad;
        key_sel = 1'b0;
        send(PT_C1);
        run_to_done(lat, nr, bad);
        checks++;
        if (lat != 12) begin errors++; $display("FAIL fips_latency: got %0d, required 12", lat); end
        checks++;
        if (o_data !== CT_C1) begin errors++; $display("FAIL fips_data: got %h, required %h", o_data, CT_C1); end
        checks++;
        if (nr != 11 || bad != 0) begin
            errors++;
            $display("FAIL fips_rounds: %0d rounds with %0d round/last errors, required 11 and 0", nr, bad);
        end
        checks++;
        if (o_ready !== 1'b0) begin errors++; $display("FAIL fips_done_ready: got %b, required 0", o_ready); end
        drain();
        checks++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_data !== '0) begin
            errors++;
            $display("FAIL fips_drain: valid=%b ready=%b data=%h, required 0/1/0", o_valid, o_ready, o_data);
        end
    endtask

    task automatic test_stall();
        int lat, kr;
        int stl [11];
        logic [127:0] snap_s;
        logic [3:0]   snap_r;
        for (int i = 0; i < 11; i++) stl[i] = 0;
        key_sel = 1'b0;
        i_key_valid = 1'b0;
        send(PT_C1);
        lat = 1;
        while (!o_valid && lat <= 100) begin
            kr = int'(o_key_round);
            if (o_key_req && (kr == 0 || kr == 5 || kr == 10) && stl[kr] < 3) begin
                i_key_valid = 1'b0;
                stl[kr]++;
                snap_s = o_dp_state;
                snap_r = o_key_round;
                tick();
                lat++;
                checks++;
                if (o_dp_state !== snap_s || o_key_round !== snap_r) begin
                    errors++;
                    $display("FAIL stall_hold: state=%h round=%0d, required %h round %0d",
                             o_dp_state, o_key_round, snap_s, snap_r);
                end
            end else begin
                i_key_valid = 1'b1;
                tick();
                lat++;
            end
        end
        i_key_valid = 1'b1;
        checks++;
        if (lat != 21) begin errors++; $display("FAIL stall_latency: got %0d, required 21", lat); end
        checks++;
        if (o_data !== CT_C1) begin errors++; $display("FAIL stall_data: got %h, required %h", o_data, CT_C1); end
        drain();
    endtask

    task automatic test_backpressure();
        int lat, nr, bad;
        logic [127:0] exp_b;
        key_sel = 1'b0;
        exp_b = encrypt(PT_B, 1'b0);
        send(PT_C1);
        run_to_done(lat, nr, bad);
        i_valid = 1'b1;
        i_data = PT_B;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (o_valid !== 1'b1 || o_data !== CT_C1 || o_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold: cycle %0d valid=%b ready=%b data=%h, required 1/0/%h",
                         c, o_valid, o_ready, o_data, CT_C1);
            end
            tick();
        end
        drain();
        checks++;
        if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_key_req !== 1'b0) begin
            errors++;
            $display("FAIL bp_after_hs: valid=%b ready=%b req=%b, required 0/1/0", o_valid, o_ready, o_key_req);
        end
        tick();
        i_valid = 1'b0;
        i_data = '0;
        checks++;
        if (o_key_req !== 1'b1 || o_dp_state !== PT_B || o_key_round !== 4'd0) begin
            errors++;
            $display("FAIL bp_accept: req=%b state=%h round=%0d, required 1/%h/0",
                     o_key_req, o_dp_state, o_key_round, PT_B);
        end
        run_to_done(lat, nr, bad);
        checks++;
        if (lat != 12 || o_data !== exp_b) begin
            errors++;
            $display("FAIL bp_second: lat=%0d data=%h, required 12/%h", lat, o_data, exp_b);
        end
        drain();
    endtask

    task automatic test_back_to_back();
        int hs, nout, nseq, seq_bad;
        bit hs_now;
        int out_cyc [2];
        logic [127:0] out_dat [2];
        logic [3:0] seq [32];
        logic [127:0] exp2;
        key_sel = 1'b0;
        exp2 = encrypt(PT_B, 1'b0);
        hs = 0; nout = 0; nseq = 0; seq_bad = 0;
        i_key_valid = 1'b1;
        i_ready = 1'b1;
        i_valid = 1'b1;
        i_data = PT_C1;
        for (int c = 0; c < 80 && nout < 2; c++) begin
            hs_now = i_valid && o_ready;
            if (o_valid) begin
                out_cyc[nout] = c;
                out_dat[nout] = o_data;
                nout++;
            end
            if (o_key_req && nseq < 32) begin
                seq[nseq] = o_key_round;
                nseq++;
            end
            tick();
            if (hs_now) begin
                hs++;
                if (hs == 1) i_data = PT_B;
                else begin i_valid = 1'b0; i_data = '0; end
            end
        end
        i_ready = 1'b0;
        i_valid = 1'b0;
        checks++;
        if (nout != 2) begin
            errors++;
            $display("FAIL b2b_count: %0d outputs, required 2", nout);
        end else begin
            checks++;
            if (out_dat[0] !== CT_C1 || out_dat[1] !== exp2) begin
                errors++;
                $display("FAIL b2b_data: %h %h, required %h %h", out_dat[0], out_dat[1], CT_C1, exp2);
            end
            checks++;
            if (out_cyc[1] - out_cyc[0] != 13) begin
                errors++;
                $display("FAIL b2b_spacing: got %0d, required 13", out_cyc[1] - out_cyc[0]);
            end
        end
        for (int k = 0; k < nseq; k++) if (seq[k] !== 4'(k % 11)) seq_bad++;
        checks++;
        if (nseq != 22 || seq_bad != 0) begin
            errors++;
            $display("FAIL b2b_rounds: %0d requests, %0d out of order, required 22 and 0", nseq, seq_bad);
        end
    endtask

    task automatic test_clear();
        int n, nval, lat, nr, bad;
        key_sel = 1'b0;
        i_key_valid = 1'b1;
        send(PT_C1);
        n = 0;
        while (!(o_key_req && o_key_round == 4'd4) && n < 30) begin tick(); n++; end
        checks++;
        if (o_key_round !== 4'd4) begin errors++; $display("FAIL clr_reach: round=%0d, required 4", o_key_round); end
        i_clear = 1'b1;
        tick();
        i_clear = 1'b0;
        checks++;
        if (o_key_req !== 1'b0 || o_ready !== 1'b1 || o_valid !== 1'b0 ||
            o_dp_state !== '0 || o_key_round !== 4'd0) begin
            errors++;
            $display("FAIL clr_idle: req=%b ready=%b valid=%b state=%h round=%0d, required 0/1/0/0/0",
                     o_key_req, o_ready, o_valid, o_dp_state, o_key_round);
        end
        nval = 0;
        for (int c = 0; c < 20; c++) begin
            if (o_valid) nval++;
            tick();
        end
        checks++;
        if (nval != 0) begin errors++; $display("FAIL clr_no_valid: %0d valid cycles, required 0", nval); end
        i_valid = 1'b1;
        i_data = PT_C1;
        i_clear = 1'b1;
        tick();
        i_clear = 1'b0;
        i_valid = 1'b0;
        checks++;
        if (o_key_req !== 1'b0 || o_ready !== 1'b1 || o_dp_state !== '0) begin
            errors++;
            $display("FAIL clr_discard: req=%b ready=%b state=%h, required 0/1/0", o_key_req, o_ready, o_dp_state);
        end
        key_sel = 1'b1;
        send(PT_B);
        run_to_done(lat, nr, bad);
        checks++;
        if (lat != 12 || o_data !== CT_B) begin
            errors++;
            $display("FAIL clr_next_block: lat=%0d data=%h, required 12/%h", lat, o_data, CT_B);
        end
        drain();
        key_sel = 1'b0;
    endtask

    task automatic test_async_reset();
        int n, lat, nr, bad;
        key_sel = 1'b0;
        i_key_valid = 1'b1;
        send(PT_C1);
        n = 0;
        while (!(o_key_req && o_key_round == 4'd7) && n < 30) begin tick(); n++; end
        #2 n_rst = 1'b0;
        #1;
        checks++;
        if ({o_ready, o_key_req, o_valid, o_dp_last} !== 4'b1000) begin
            errors++;
            $display("FAIL arst_flags: ready/req/valid/last=%b, required 1000",
                     {o_ready, o_key_req, o_valid, o_dp_last});
        end
        checks++;
        if (o_data !== '0 || o_dp_state !== '0 || o_key_round !== 4'd0) begin
            errors++;
            $display("FAIL arst_data: o_data=%h o_dp_state=%h round=%0d, required all zero",
                     o_data, o_dp_state, o_key_round);
        end
        @(negedge clk);
        n_rst = 1'b1;
        tick();
        send(PT_C1);
        run_to_done(lat, nr, bad);
        checks++;
        if (lat != 12 || o_data !== CT_C1 || bad != 0) begin
            errors++;
            $display("FAIL arst_fresh: lat=%0d data=%h bad=%0d, required 12/%h/0", lat, o_data, bad, CT_C1);
        end
        drain();
    endtask

    initial begin
        i_clear = 1'b0;
        i_valid = 1'b0;
        i_data = '0;
        i_key_valid = 1'b0;
        i_ready = 1'b0;
        key_sel = 1'b0;
        n_rst = 1'b1;
        for (int i = 0; i < 256; i++) sb[i] = sbox_calc(8'(i));
        expand(K_C1, 1'b0);
        expand(K_B, 1'b1);
        test_reset();
        test_fips();
        test_stall();
        test_backpressure();
        test_back_to_back();
        test_clear();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
